// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin arbiter between two requesters sharing one APB master,
// with a per-transaction timeout so a hung slave cannot stall a requester.
// Ports:
//   PCLK, PRESET                  clock, asynchronous active-low reset
//   sX_transfer/write/addr/wdata  requester X request level and payload (X = 0 CPU, 1 DMA)
//   sX_rdata/ready/err            requester X completion pulse, read data, timeout flag
//   transfer/write/addr/wdata     start pulse and latched payload towards the APB master
//   rdata/ready                   read data and completion pulse from the APB master
//   grant, busy                   current owner index, high while a transaction is in flight
module apb_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              s0_transfer,
    input  logic              s0_write,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s0_ready,
    output logic              s0_err,
    input  logic              s1_transfer,
    input  logic              s1_write,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s1_ready,
    output logic              s1_err,
    output logic              transfer,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic              grant,
    output logic              busy
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = TIMEOUT_CYCLES != 0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req, pick, timeout_hit, done;

    assign req         = s0_transfer | s1_transfer;
    // on a tie the requester that did not win last time goes next
    assign pick        = (s0_transfer & s1_transfer) ? ~last_q : s1_transfer;
    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);
    // a real ready takes precedence over a timeout landing in the same cycle
    assign done        = (state_q == S_WAIT) && (ready || timeout_hit);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: if (req) begin
                state_d = S_ISSUE;
                grant_d = pick;
                last_d  = pick;
                write_d = pick ? s1_write : s0_write;
                addr_d  = pick ? s1_addr : s0_addr;
                wdata_d = pick ? s1_wdata : s0_wdata;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d = done ? S_IDLE : S_WAIT;
                cnt_d   = done ? '0 : cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        transfer = state_q == S_ISSUE;
        busy     = state_q != S_IDLE;
        grant    = grant_q;
        write    = write_q;
        addr     = addr_q;
        wdata    = wdata_q;
        s0_ready = done && !grant_q;
        s1_ready = done && grant_q;
        s0_err   = s0_ready && !ready;
        s1_err   = s1_ready && !ready;
        s0_rdata = (s0_ready && ready) ? rdata : '0;
        s1_rdata = (s1_ready && ready) ? rdata : '0;
    end
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: self-checking bench for apb_bus_arbiter (vectors, corner sequences, random vs model)
module tb_apb_bus_arbiter;
    localparam int TO = 8;

    logic        PCLK, PRESET;
    logic        s0_transfer, s0_write, s1_transfer, s1_write;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata, s0_rdata, s1_rdata;
    logic        s0_ready, s0_err, s1_ready, s1_err;
    logic        transfer, write, ready, grant, busy;
    logic [31:0] addr, wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_act, m_gnt, m_last, m_wr;
    int          m_age;
    logic [31:0] m_addr, m_wd;
    bit          seen0, seen1;

    apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .s0_transfer(s0_transfer), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rdata(s0_rdata), .s0_ready(s0_ready), .s0_err(s0_err),
        .s1_transfer(s1_transfer), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rdata(s1_rdata), .s1_ready(s1_ready), .s1_err(s1_err),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .grant(grant), .busy(busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk1(input string n, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an in-flight transaction is described by its owner and
    // its age (0 = start pulse cycle, 1.. = cycles spent waiting for the slave).
    task automatic sample();
        bit e_done;
        #1;
        seen0 = 1'b0;
        seen1 = 1'b0;
        if (!PRESET) begin
            m_act = 0; m_gnt = 0; m_last = 1; m_wr = 0; m_age = 0; m_addr = '0; m_wd = '0;
        end
        e_done = PRESET && m_act && m_age >= 1 && (ready || m_age == TO);
        chk1("transfer", transfer, m_act && m_age == 0);
        chk1("busy", busy, m_act);
        chk1("grant", grant, m_gnt);
        chk1("write", write, m_wr);
        chk32("addr", addr, m_addr);
        chk32("wdata", wdata, m_wd);
        chk1("s0_ready", s0_ready, e_done && !m_gnt);
        chk1("s1_ready", s1_ready, e_done && m_gnt);
        chk1("s0_err", s0_err, e_done && !m_gnt && !ready);
        chk1("s1_err", s1_err, e_done && m_gnt && !ready);
        chk32("s0_rdata", s0_rdata, (e_done && !m_gnt && ready) ? rdata : 32'h0);
        chk32("s1_rdata", s1_rdata, (e_done && m_gnt && ready) ? rdata : 32'h0);
        if (!PRESET) return;
        seen0 = e_done && !m_gnt;
        seen1 = e_done && m_gnt;
        if (!m_act) begin
            if (s0_transfer || s1_transfer) begin
                m_gnt  = (s0_transfer && s1_transfer) ? !m_last : s1_transfer;
                m_last = m_gnt;
                m_wr   = m_gnt ? s1_write : s0_write;
                m_addr = m_gnt ? s1_addr : s0_addr;
                m_wd   = m_gnt ? s1_wdata : s0_wdata;
                m_act  = 1;
                m_age  = 0;
            end
        end else if (e_done) m_act = 0;
        else m_age++;
    endtask

    task automatic adv();
        @(negedge PCLK);
    endtask

    typedef struct {
        bit          r0, r1, wr;
        logic [31:0] a0, a1, wd0, wd1, rd;
        int          dly;
        bit          eg;
        logic [31:0] ea, ewd;
        bit          ee;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 0, 1, 32'h1000_2000, 32'h0, 32'hA5A5_0001, 32'h0, 32'h0, 3, 0, 32'h1000_2000, 32'hA5A5_0001, 0, 32'h0};
        vecs[1] = '{0, 1, 0, 32'h0, 32'h1000_3004, 32'h0, 32'h0, 32'h0000_00C3, 1, 1, 32'h1000_3004, 32'h0, 0, 32'h0000_00C3};
        vecs[2] = '{1, 1, 1, 32'h2000_0000, 32'h3000_0000, 32'h11, 32'h22, 32'hDEAD, 2, 0, 32'h2000_0000, 32'h11, 0, 32'hDEAD};
        vecs[3] = '{1, 1, 1, 32'h2000_0000, 32'h3000_0000, 32'h11, 32'h22, 32'hBEEF, 1, 1, 32'h3000_0000, 32'h22, 0, 32'hBEEF};
        vecs[4] = '{1, 0, 0, 32'h4000_0010, 32'h0, 32'h77, 32'h0, 32'h1234, 0, 0, 32'h4000_0010, 32'h77, 1, 32'h0};
        vecs[5] = '{0, 1, 0, 32'h0, 32'h5000_0020, 32'h0, 32'h99, 32'h55, 8, 1, 32'h5000_0020, 32'h99, 0, 32'h55};
        vecs[6] = '{1, 0, 1, 32'h6000_0000, 32'h0, 32'hCAFE, 32'h0, 32'h66, 7, 0, 32'h6000_0000, 32'hCAFE, 0, 32'h66};

        PRESET = 0; ready = 0; rdata = '0;
        s0_transfer = 0; s0_write = 0; s0_addr = '0; s0_wdata = '0;
        s1_transfer = 0; s1_write = 0; s1_addr = '0; s1_wdata = '0;
        adv();
        repeat (2) begin sample(); adv(); end
        PRESET = 1;

        foreach (vecs[i]) begin
            s0_transfer = vecs[i].r0; s0_write = vecs[i].wr; s0_addr = vecs[i].a0; s0_wdata = vecs[i].wd0;
            s1_transfer = vecs[i].r1; s1_write = vecs[i].wr; s1_addr = vecs[i].a1; s1_wdata = vecs[i].wd1;
            ready = 0; rdata = vecs[i].rd;
            sample();
            chk1("vec_idle_transfer", transfer, 1'b0);
            adv();
            sample();
            chk1("vec_issue_transfer", transfer, 1'b1);
            chk1("vec_grant", grant, vecs[i].eg);
            chk32("vec_addr", addr, vecs[i].ea);
            chk32("vec_wdata", wdata, vecs[i].ewd);
            chk1("vec_write", write, vecs[i].wr);
            adv();
            for (int k = 1; k <= TO; k++) begin
                ready = (k == vecs[i].dly);
                sample();
                chk1("vec_wait_transfer", transfer, 1'b0);
                if (k == vecs[i].dly || k == TO) begin
                    chk1("vec_ready", vecs[i].eg ? s1_ready : s0_ready, 1'b1);
                    chk1("vec_other_ready", vecs[i].eg ? s0_ready : s1_ready, 1'b0);
                    chk1("vec_err", vecs[i].eg ? s1_err : s0_err, vecs[i].ee);
                    chk32("vec_rdata", vecs[i].eg ? s1_rdata : s0_rdata, vecs[i].erd);
                    chk32("vec_other_rdata", vecs[i].eg ? s0_rdata : s1_rdata, 32'h0);
                    adv();
                    break;
                end
                chk1("vec_early_ready", s0_ready | s1_ready, 1'b0);
                adv();
            end
            s0_transfer = 0; s1_transfer = 0; ready = vecs[i].ee;
            sample();
            chk1("vec_post_busy", busy, 1'b0);
            chk1("vec_late_ready", s0_ready | s1_ready, 1'b0);
            adv();
        end

        // fairness from reset with both requesters held and the slave always ready
        PRESET = 0; ready = 0;
        sample(); adv();
        PRESET = 1;
        s0_transfer = 1; s0_addr = 32'hA000_0000; s0_write = 1; s0_wdata = 32'h1;
        s1_transfer = 1; s1_addr = 32'hB000_0000; s1_write = 0; s1_wdata = 32'h2;
        ready = 1;
        begin
            int seen = 0, last_c = 0;
            for (int c = 0; c < 40 && seen < 4; c++) begin
                sample();
                if (transfer) begin
                    chk1("fair_grant", grant, seen[0]);
                    chk32("fair_addr", addr, seen[0] ? 32'hB000_0000 : 32'hA000_0000);
                    if (seen > 0) chk32("fair_gap", c - last_c, 3);
                    last_c = c;
                    seen++;
                end
                adv();
            end
            chk32("fair_count", seen, 4);
        end
        s0_transfer = 0; s1_transfer = 0; ready = 0;
        sample(); adv();
        sample(); adv();

        // asynchronous reset in the middle of a wait
        s0_transfer = 1; s0_addr = 32'hC000_0000;
        repeat (3) begin sample(); adv(); end
        chk1("rst_pre_busy", busy, 1'b1);
        PRESET = 0; ready = 1;
        repeat (3) begin
            sample();
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_transfer", transfer, 1'b0);
            chk1("rst_ready", s0_ready | s1_ready, 1'b0);
            adv();
        end
        PRESET = 1; s0_transfer = 0;
        repeat (2) begin
            sample();
            chk1("rst_stale_ready", s0_ready | s1_ready, 1'b0);
            adv();
        end
        ready = 0;

        // s1 requests and withdraws while s0 is waiting
        s0_transfer = 1; s0_addr = 32'hD000_0000;
        sample(); adv();
        sample(); adv();
        s1_transfer = 1; s1_addr = 32'hE000_0000;
        sample(); adv();
        s1_transfer = 0;
        sample(); adv();
        ready = 1;
        sample();
        chk1("wd_s0_ready", s0_ready, 1'b1);
        adv();
        s0_transfer = 0; ready = 0;
        repeat (3) begin
            sample();
            chk1("wd_transfer", transfer, 1'b0);
            chk1("wd_busy", busy, 1'b0);
            adv();
        end

        // randomized traffic checked against the model
        seen0 = 0; seen1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seen0) s0_transfer = 0;
            else if (!s0_transfer && $urandom_range(0, 2) == 0) begin
                s0_transfer = 1; s0_write = 1'($urandom); s0_addr = $urandom; s0_wdata = $urandom;
            end else if (s0_transfer && $urandom_range(0, 31) == 0) s0_transfer = 0;
            if (seen1) s1_transfer = 0;
            else if (!s1_transfer && $urandom_range(0, 2) == 0) begin
                s1_transfer = 1; s1_write = 1'($urandom); s1_addr = $urandom; s1_wdata = $urandom;
            end else if (s1_transfer && $urandom_range(0, 31) == 0) s1_transfer = 0;
            ready = ($urandom_range(0, 4) == 0);
            rdata = $urandom;
            sample();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
Two-requester arbiter in front of the APB master's internal transfer interface (transfer/ready/write/addr/wdata/rdata). Requester 0 is the CPU_RV32I data bus; requester 1 is a bus-mastering peripheral, the planned DMA engine. The arbiter sequences exactly one transaction at a time into the APB master. It uses round-robin arbitration and a per-transaction timeout, so a hung slave cannot stall the core.

Parameters:
ADDR_W, 32, address width of requesters and downstream
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, max cycles in WAIT before forced completion; 0 disables timeout

Ports:
PCLK  in  1  single clock, all state rising-edge
PRESET  in  1  asynchronous reset, active-low
s0_transfer  in  1  requester 0 request level
s0_write  in  1  requester 0 write(1)/read(0)
s0_addr  in  ADDR_W  requester 0 address
s0_wdata  in  DATA_W  requester 0 write data
s0_rdata  out  DATA_W  requester 0 read data, valid with s0_ready
s0_ready  out  1  requester 0 completion pulse
s0_err  out  1  requester 0 timeout flag, valid with s0_ready
s1_transfer, s1_write, s1_addr, s1_wdata, s1_rdata, s1_ready, s1_err  (same as s0, requester 1)
transfer  out  1  one-cycle start pulse to APB master
write  out  1  latched direction
addr  out  ADDR_W  latched address
wdata  out  DATA_W  latched write data
rdata  in  DATA_W  read data from APB master
ready  in  1  completion pulse from APB master
grant  out  1  index of requester currently owning the bus (debug)
busy  out  1  high in ISSUE and WAIT

Behaviour:
- Reset (PRESET low, async): state IDLE; transfer, write, busy, grant, all s*_ready and s*_err = 0; addr, wdata = 0; s*_rdata = 0; last_grant = 1, so requester 0 wins the first tie; timeout counter = 0.
- Requester protocol:
  - Requester raises sX_transfer and holds write/addr/wdata stable until sX_ready.
  - It deasserts transfer in the cycle after sX_ready; if still high in that cycle, it is taken as a new request.
- IDLE:
  - Sample s0_transfer and s1_transfer.
  - One requesting: grant it.
  - Both requesting: grant the index != last_grant.
  - On grant: latch write/addr/wdata from the winner, set grant and last_grant, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle): transfer = 1, busy = 1, go to WAIT.
- WAIT:
  - transfer = 0; write/addr/wdata held; timeout counter increments each cycle.
  - If ready = 1: s[grant]_ready = 1 combinationally in the same cycle; s[grant]_rdata = rdata (pass-through); s[grant]_err = 0; counter cleared; go to IDLE.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: s[grant]_ready = 1, s[grant]_err = 1, s[grant]_rdata = 0; counter cleared; go to IDLE.
  - A late ready arriving after a timeout, while in IDLE, is ignored.
- Non-granted requester: sX_ready = 0, sX_err = 0, sX_rdata = 0 at all times.
- Latency:
  - Request sampled in IDLE at cycle N; transfer pulses at N+1.
  - Completion is in the same cycle as ready.
  - Earliest next grant is the cycle after completion (one-cycle IDLE gap minimum).
- Fairness: with both requesters asserted continuously, grants strictly alternate 0,1,0,1; neither waits more than one transaction.
- A requester dropping transfer before its grant is legal; the request is withdrawn. Dropping it after grant has no effect, and the transaction completes.
- Counter width: clog2(TIMEOUT_CYCLES+1), saturating never needed.
- The arbiter checks no address range; decode stays in the APB master.

Test Plan:
- Reset/idle: hold PRESET low 3 cycles mid-WAIT → transfer = 0, busy = 0, s0_ready = s1_ready = 0, state IDLE immediately (async); no stale ready after release.
- Single CPU write: s0 write addr 0x1000_2000, wdata 0xA5A5_0001; APB ready 3 cycles after transfer → transfer is a 1-cycle pulse one cycle after request, addr/wdata held, s0_ready pulses once with s0_err = 0, s1 untouched.
- Read pass-through: s1 read addr 0x1000_3004, APB returns rdata 0x0000_00C3 with ready → s1_rdata = 0x0000_00C3 in the ready cycle; s0_rdata stays 0.
- Simultaneous requests held for 4 transactions from reset → grant order 0,1,0,1; each transfer pulse separated by at least one IDLE cycle; latched addr matches granted requester every time.
- Timeout: TIMEOUT_CYCLES = 8, ready never asserted → s0_ready = 1 with s0_err = 1 and s0_rdata = 0 exactly 8 WAIT cycles after ISSUE. A subsequent spurious ready in IDLE causes no ready on either requester. The next request proceeds normally.
- Withdrawal: s1 raises transfer while s0 in WAIT, drops it before s0 completes → after s0 completes the arbiter stays IDLE, no transfer pulse.
